// File: rtl/sparse_ram_pkg.sv
// Shared types and helpers for the sparse RAM writer.
package sparse_ram_pkg;

    typedef enum logic [1:0] {
        BW_16X = 2'd0,
        BW_8X  = 2'd1,
        BW_4X  = 2'd2
    } bitwidth_e;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        COMMIT,
        DONE
    } writer_state_e;

    localparam int DEF_OUTPUT_DIM = 4;
    localparam int MAX_SLOTS      = DEF_OUTPUT_DIM * 4;
    localparam int LEN_ADDR       = 0;

    // Modes 2 and 3 both pack four entries per slot group.
    function automatic int entries_for_bitwidth(input logic [1:0] bw, input int max_slots);
        if (bw == BW_16X) return max_slots;
        if (bw == BW_8X)  return max_slots / 2;
        return max_slots / 4;
    endfunction

endpackage

// File: rtl/sparse_beat_buffer.sv
// Holds one accepted beat and presents its live slots lowest-first.
// WRITER_ZERO_SKIP_EN: zero-valued slots are dropped at load time.
module sparse_beat_buffer #(
    parameter int N_SLOTS = 16,
    parameter int VAL_W   = 8,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = $clog2(N_SLOTS) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [CNT_W-1:0]                load_count,
    input  logic [N_SLOTS-1:0][VAL_W-1:0]   value_in,
    input  logic [N_SLOTS-1:0][IDX_W-1:0]   index_in,
    input  logic                            advance,
    output logic                            load_nonempty,
    output logic [VAL_W-1:0]                slot_value,
    output logic [IDX_W-1:0]                slot_index,
    output logic                            slot_last
);
    localparam int SEL_W = $clog2(N_SLOTS);

    logic [N_SLOTS-1:0][VAL_W-1:0] vals;
    logic [N_SLOTS-1:0][IDX_W-1:0] idxs;
    logic [N_SLOTS-1:0]            mask;
    logic [N_SLOTS-1:0]            load_mask;
    logic [SEL_W-1:0]              sel;

    // One bit per slot still to be emitted; skipping is just a cleared bit.
    always_comb begin
        load_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
`ifdef WRITER_ZERO_SKIP_EN
            load_mask[i] = (CNT_W'(i) < load_count) && (value_in[i] != '0);
`else
            load_mask[i] = CNT_W'(i) < load_count;
`endif
        end
    end

    assign load_nonempty = |load_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            vals <= '0;
            idxs <= '0;
        end else if (load) begin
            mask <= load_mask;
            vals <= value_in;
            idxs <= index_in;
        end else if (advance) begin
            mask <= mask & (mask - N_SLOTS'(1));
        end
    end

    always_comb begin
        sel = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) sel = SEL_W'(i);
        end
    end

    assign slot_value = vals[sel];
    assign slot_index = idxs[sel];
    assign slot_last  = (mask & (mask - N_SLOTS'(1))) == '0;

endmodule

// File: rtl/sparse_ram_writer.sv
// Packs sparse (value, index) beats into the length-prefixed RAM layout.
// WRITER_ZERO_SKIP_EN (in sparse_beat_buffer) drops zero-valued entries.
module sparse_ram_writer
    import sparse_ram_pkg::*;
#(
    parameter int RAM_ADDRESS_WIDTH      = 14,
    parameter int RAM_VALUE_WIDTH        = 24,
    parameter int INDEX_WIDTH            = 4,
    parameter int OUTPUT_DIM             = DEF_OUTPUT_DIM,
    parameter int SMALLEST_ELEMENT_WIDTH = 2
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [1:0]                                            bitwidth,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [$clog2(OUTPUT_DIM*4):0]                         in_count,
    input  logic [OUTPUT_DIM*4-1:0][4*SMALLEST_ELEMENT_WIDTH-1:0] value_in,
    input  logic [OUTPUT_DIM*4-1:0][INDEX_WIDTH-1:0]              index_in,
    input  logic                                                  finish,
    input  logic                                                  clear,
    output logic                                                  ram_write_enable,
    output logic [RAM_ADDRESS_WIDTH-1:0]                          ram_address,
    output logic [RAM_VALUE_WIDTH-1:0]                            ram_value,
    output logic [INDEX_WIDTH-1:0]                                ram_indices_value,
    output logic                                                  done,
    output logic                                                  overflow
);
    localparam int N_SLOTS = OUTPUT_DIM * 4;
    localparam int CNT_W   = $clog2(N_SLOTS) + 1;
    localparam int VAL_W   = 4 * SMALLEST_ELEMENT_WIDTH;
    localparam logic [RAM_ADDRESS_WIDTH:0] ADDR_ONE = 1;

    writer_state_e state, state_nxt;
    // Extra top bit marks that the last address has been written.
    logic [RAM_ADDRESS_WIDTH:0] next_addr;
    logic                       pending_finish;
    logic                       full, accept, load_nonempty, slot_last;
    logic [VAL_W-1:0]           slot_value;
    logic [INDEX_WIDTH-1:0]     slot_index;
    logic [CNT_W-1:0]           ent, cnt;

    assign full     = next_addr[RAM_ADDRESS_WIDTH];
    assign ent      = CNT_W'(entries_for_bitwidth(bitwidth, N_SLOTS));
    assign cnt      = (in_count > ent) ? ent : in_count;
    assign in_ready = (state == ACCEPT) && !reset;
    assign accept   = in_valid && in_ready;

    sparse_beat_buffer #(
        .N_SLOTS (N_SLOTS),
        .VAL_W   (VAL_W),
        .IDX_W   (INDEX_WIDTH),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk           (clk),
        .reset         (reset),
        .load          (accept),
        .load_count    (cnt),
        .value_in      (value_in),
        .index_in      (index_in),
        .advance       (state == DRAIN),
        .load_nonempty (load_nonempty),
        .slot_value    (slot_value),
        .slot_index    (slot_index),
        .slot_last     (slot_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCEPT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT: begin
                if (accept)                          state_nxt = load_nonempty ? DRAIN : ACCEPT;
                else if (finish || pending_finish)   state_nxt = COMMIT;
            end
            DRAIN:  if (slot_last) state_nxt = ACCEPT;
            COMMIT: state_nxt = DONE;
            DONE:   if (clear) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // Dropped entries still take their drain cycle so timing is data-independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_addr      <= ADDR_ONE;
            pending_finish <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (accept && finish)                           pending_finish <= 1'b1;
                    else if (!accept && (finish || pending_finish)) pending_finish <= 1'b0;
                end
                DRAIN: begin
                    if (finish) pending_finish <= 1'b1;
                    if (full)   overflow       <= 1'b1;
                    else        next_addr      <= next_addr + ADDR_ONE;
                end
                DONE: begin
                    if (clear) begin
                        next_addr      <= ADDR_ONE;
                        pending_finish <= 1'b0;
                        overflow       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_write_enable  = 1'b0;
        ram_address       = '0;
        ram_value         = '0;
        ram_indices_value = '0;
        done              = 1'b0;
        case (state)
            DRAIN: begin
                if (!full) begin
                    ram_write_enable  = 1'b1;
                    ram_address       = next_addr[RAM_ADDRESS_WIDTH-1:0];
                    ram_value         = RAM_VALUE_WIDTH'(slot_value);
                    ram_indices_value = slot_index;
                end
            end
            COMMIT: begin
                ram_write_enable = 1'b1;
                ram_address      = RAM_ADDRESS_WIDTH'(LEN_ADDR);
                ram_value        = RAM_VALUE_WIDTH'(next_addr - ADDR_ONE);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sparse_ram_writer.sv
// Scoreboard bench for sparse_ram_writer: a stream-level model queues expected
// RAM writes, and a monitor compares every write the DUT makes.
module tb_sparse_ram_writer;

    localparam int  MAXE = (1 << 14) - 1;
`ifdef WRITER_ZERO_SKIP_EN
    localparam bit  SKIP = 1'b1;
`else
    localparam bit  SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        bitwidth;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_count;
    logic [15:0][7:0]  value_in;
    logic [15:0][3:0]  index_in;
    logic              finish;
    logic              clear;
    logic              ram_write_enable;
    logic [13:0]       ram_address;
    logic [23:0]       ram_value;
    logic [3:0]        ram_indices_value;
    logic              done;
    logic              overflow;

    sparse_ram_writer dut (
        .clk               (clk),
        .reset             (reset),
        .bitwidth          (bitwidth),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_count          (in_count),
        .value_in          (value_in),
        .index_in          (index_in),
        .finish            (finish),
        .clear             (clear),
        .ram_write_enable  (ram_write_enable),
        .ram_address       (ram_address),
        .ram_value         (ram_value),
        .ram_indices_value (ram_indices_value),
        .done              (done),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int val;
        int idx;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  mlen   = 0;   // entries stored so far in the current stream
    bit  movf   = 1'b0;

    task automatic chk(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (ram_write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d val=%0d idx=%0d, need no write",
                         ram_address, ram_value, ram_indices_value);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (int'(ram_address) != e.addr || int'(ram_value) != e.val ||
                    int'(ram_indices_value) != e.idx) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%0d val=%0d idx=%0d, need addr=%0d val=%0d idx=%0d",
                             ram_address, ram_value, ram_indices_value, e.addr, e.val, e.idx);
                end
            end
        end
    end

    function automatic int model_entries(input int bw);
        if (bw == 0) return 16;
        if (bw == 1) return 8;
        return 4;
    endfunction

    task automatic model_commit();
        wr_t w;
        w.addr = 0; w.val = mlen; w.idx = 0;
        exp_q.push_back(w);
    endtask

    task automatic model_beat(input bit fin);
        int n;
        wr_t w;
        n = int'(in_count);
        if (n > model_entries(int'(bitwidth))) n = model_entries(int'(bitwidth));
        for (int i = 0; i < n; i++) begin
            if (SKIP && value_in[i] == 8'd0) continue;
            if (mlen < MAXE) begin
                w.addr = mlen + 1; w.val = int'(value_in[i]); w.idx = int'(index_in[i]);
                exp_q.push_back(w);
                mlen++;
            end else begin
                movf = 1'b1;
            end
        end
        if (fin) model_commit();
    endtask

    // mode 0: random values with zeros, 1: random nonzero, 2: caller-set values
    task automatic drive_beat(input int bw, input int cnt, input bit fin, input int mode);
        bit acc;
        bitwidth = 2'(bw);
        in_count = 5'(cnt);
        if (mode != 2) begin
            for (int i = 0; i < 16; i++) begin
                if (mode == 0 && $urandom_range(0, 3) == 0) value_in[i] = 8'd0;
                else value_in[i] = 8'($urandom_range(1, 255));
                index_in[i] = 4'($urandom_range(0, 15));
            end
        end
        finish   = fin;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                model_beat(fin);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finish   = 1'b0;
        chk("beat_accepted", int'(acc), 1);
    endtask

    task automatic do_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        model_commit();
    endtask

    task automatic wait_done_and_clear(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk({tag, "_done"}, int'(seen), 1);
        chk({tag, "_overflow"}, int'(overflow), int'(movf));
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        chk({tag, "_ready_in_done"}, int'(in_ready), 0);
        // beats and finish offered while DONE must be ignored
        in_valid = 1'b1; finish = 1'b1; in_count = 5'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0; finish = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        mlen = 0; movf = 1'b0;
        @(negedge clk);
        chk({tag, "_done_cleared"}, int'(done), 0);
        chk({tag, "_overflow_cleared"}, int'(overflow), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; bitwidth = '0; in_valid = 1'b0; in_count = '0;
        value_in = '0; index_in = '0; finish = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(in_ready), 0);
        chk("reset_we", int'(ram_write_enable), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 1);
        @(posedge clk); #1;

        // values 1..4, indices 5..8, then a separate finish
        for (int i = 0; i < 16; i++) begin
            value_in[i] = 8'(i + 1);
            index_in[i] = 4'(i + 5);
        end
        drive_beat(2, 4, 1'b0, 2);
        do_finish();
        wait_done_and_clear("basic4");

        // full 16-entry beat, then 3 entries with finish coincident
        drive_beat(0, 16, 1'b0, 1);
        drive_beat(0, 3, 1'b1, 1);
        wait_done_and_clear("pending19");

        // count clamped to 8 in 8x mode
        drive_beat(1, 9, 1'b0, 1);
        do_finish();
        wait_done_and_clear("clamp8");

        // empty stream
        do_finish();
        wait_done_and_clear("empty");

        // address space overflow
        for (int b = 0; b < 1026; b++) drive_beat(0, 16, 1'b0, 1);
        do_finish();
        wait_done_and_clear("overflow");

        // reset while draining, then a fresh 2-entry stream
        drive_beat(0, 16, 1'b0, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        mlen = 0; movf = 1'b0;
        @(negedge clk);
        chk("midreset_we", int'(ram_write_enable), 0);
        chk("midreset_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive_beat(2, 2, 1'b1, 1);
        wait_done_and_clear("after_reset");

        // zero-valued entries: skipped or written depending on build
        value_in = '0;
        value_in[1] = 8'd5; value_in[3] = 8'd9;
        for (int i = 0; i < 4; i++) index_in[i] = 4'(i + 1);
        drive_beat(2, 4, 1'b1, 2);
        wait_done_and_clear("zeros");

        // randomized streams
        for (int s = 0; s < 20; s++) begin
            int nb;
            bit tail_fin;
            nb = $urandom_range(1, 6);
            tail_fin = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++)
                drive_beat($urandom_range(0, 3), $urandom_range(0, 20),
                           (b == nb - 1) && tail_fin, 0);
            if (!tail_fin) do_finish();
            wait_done_and_clear("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sparse_ram_writer.md
Name: sparse_ram_writer

Overview:
Packs a stream of sparse (value, index) beats into the compressed weight/activation RAM layout consumed by the RAM-backed FIFO reader. Address 0 holds the entry count; entries occupy addresses 1..length, one per RAM word, with the index in the parallel index RAM. The block sits between the PE output compressor and the RAM write port, and writes the length word last so that a stream only becomes valid once it is complete.

Parameters:
RAM_ADDRESS_WIDTH, 14, RAM address width; max entries = 2^RAM_ADDRESS_WIDTH-1
RAM_VALUE_WIDTH, 24, RAM data word width; holds the length and zero-extended values
INDEX_WIDTH, 4, width of one sparse index
OUTPUT_DIM, 4, beat slot count is OUTPUT_DIM*4
SMALLEST_ELEMENT_WIDTH, 2, value slot width is 4*SMALLEST_ELEMENT_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bitwidth  in  2  element mode: 0 gives 16 entries/beat, 1 gives 8, 2 or 3 gives 4; sampled at beat accept
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready at posedge
in_count  in  $clog2(OUTPUT_DIM*4)+1  valid entries in beat, clamped to entries/beat
value_in  in  [OUTPUT_DIM*4][4*SMALLEST_ELEMENT_WIDTH]  beat values, slot 0 written first
index_in  in  [OUTPUT_DIM*4][INDEX_WIDTH]  beat indices
finish  in  1  end of stream; level-sampled, latched as pending
clear  in  1  leaves DONE and starts a new stream
ram_write_enable  out  1  RAM write strobe
ram_address  out  RAM_ADDRESS_WIDTH  write address
ram_value  out  RAM_VALUE_WIDTH  write data
ram_indices_value  out  INDEX_WIDTH  index RAM write data; 0 on the length write
done  out  1  length word committed
overflow  out  1  sticky; entries were dropped

Behaviour:
- States: ACCEPT, DRAIN, COMMIT, DONE. Reset enters ACCEPT with next_addr=1, pending_finish=0, and all outputs 0.
- in_ready is high only in ACCEPT and while reset is low.
- ACCEPT:
  - On accept, latch the beat, bitwidth and cnt=min(in_count, entries/beat).
  - If cnt>0, go to DRAIN. If cnt=0, stay in ACCEPT.
  - If finish (or pending_finish) is high with no accept, go to COMMIT.
  - If finish coincides with an accept, set pending_finish and drain first.
- DRAIN:
  - Each cycle, registered outputs: ram_write_enable=1, ram_address=next_addr, ram_value=zero-extended slot k, ram_indices_value=index slot k. Then k++ and next_addr++.
  - For an accept at edge T, the first write is visible in cycle T+1. A beat of n entries occupies n cycles, back-to-back.
  - After the last slot, return to ACCEPT. finish seen during DRAIN sets pending_finish.
- Full: if next_addr == 2^RAM_ADDRESS_WIDTH-1 has already been written, further entries are dropped: no write, overflow=1 sticky, and the drain still consumes cycles.
- COMMIT: one cycle with ram_write_enable=1, ram_address=0, ram_value=next_addr-1 zero-extended, ram_indices_value=0. Then go to DONE.
- DONE:
  - done=1 and ram_write_enable=0; in_valid and finish are ignored.
  - clear returns to ACCEPT and resets next_addr=1, overflow=0, pending_finish=0.
  - clear in any other state is ignored.
- Empty stream: finish before any beat commits length 0.
- Reset mid-stream: all state is discarded and no length word is written. The RAM keeps its prior address-0 contents, so the upstream must re-run the stream.
- ram_write_enable is 0 in every cycle not listed above.

Optional Feature:
WRITER_ZERO_SKIP_EN
- Defined: slots whose value equals 0 are skipped. They cost no cycle, no address and no count, and the length reflects only nonzero entries. A beat that is all zero returns directly to ACCEPT.
- Undefined: every slot below cnt is written verbatim, including zeros.

Decomposition:
Shared package sparse_ram_pkg holds:
- bitwidth_e (BW_16X, BW_8X, BW_4X)
- function entries_for_bitwidth
- writer_state_e
- localparams MAX_SLOTS=OUTPUT_DIM*4 and LEN_ADDR=0

One sub-module, sparse_beat_buffer: latches the beat and emits slots in order with a last flag, and owns the zero-skip logic. The FSM, address counter and overflow logic stay in the top module.

Test Plan:
- bitwidth=2, one beat with in_count=4 (values 1,2,3,4; idx 5,6,7,8), then finish → writes addr1..4 in cycles T+1..T+4, then addr0=4, then done=1.
- bitwidth=0, a full 16-entry beat followed by a 3-entry beat, finish held with the second accept → 19 entry writes, length=19, pending finish honoured with no extra beat.
- in_count=9 with bitwidth=1 → clamped to 8 writes; finish with no beats → addr0=0 written, done=1.
- RAM_ADDRESS_WIDTH=3, stream 10 entries → addr1..7 written, overflow=1, length=7.
- Reset asserted mid-DRAIN, then a new 2-entry stream → writes restart at addr1, length=2, overflow=0.
- WRITER_ZERO_SKIP_EN, beat values 0,5,0,9 → only 5 and 9 written at addr1 and addr2, length=2.
